// File: rtl/stoch_matrix_mult_signed.sv
// ---------------------------------------------------------------------------
// stoch_matrix_mult_signed
//
// Signed (bipolar, split-rail) stochastic matrix multiplier Y = A x B.
// Each element travels as a positive rail (_p) and a negative rail (_m).
// Every accepted cycle, each output (i,j) adds the positive product terms to
// a signed residual and subtracts the negative ones. It emits a single +1 or
// -1 pulse when the running sum allows, and carries the rest forward in a
// saturating residual counter.
// A start/busy/done handshake frames a window of STREAM_LEN accepted cycles.
//
// Ports:
//   CLK        clock, rising edge
//   nRST       asynchronous active-low reset
//   start      single-cycle pulse; opens or restarts a window
//   en         stream-valid qualifier; accepted when busy && en && !start
//   A_p / A_m  positive / negative rails of A  [NUM_ROWS][NUM_MID]
//   B_p / B_m  positive / negative rails of B  [NUM_MID][NUM_COLS]
//   Y_p / Y_m  positive / negative rails of Y  [NUM_ROWS][NUM_COLS], registered
//   busy       window in progress
//   done       one-cycle pulse on the edge that ends the window
// ---------------------------------------------------------------------------
module stoch_matrix_mult_signed #(
    parameter int NUM_ROWS   = 2,
    parameter int NUM_MID    = 2,
    parameter int NUM_COLS   = 2,
    parameter int CNT_W      = $clog2(NUM_MID) + 3,
    parameter int STREAM_LEN = 256,
    parameter int LEN_W      = $clog2(STREAM_LEN + 1)
) (
    input  logic                               CLK,
    input  logic                               nRST,
    input  logic                               start,
    input  logic                               en,
    input  logic [NUM_ROWS-1:0][NUM_MID-1:0]   A_p,
    input  logic [NUM_ROWS-1:0][NUM_MID-1:0]   A_m,
    input  logic [NUM_MID-1:0][NUM_COLS-1:0]   B_p,
    input  logic [NUM_MID-1:0][NUM_COLS-1:0]   B_m,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0]  Y_p,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0]  Y_m,
    output logic                               busy,
    output logic                               done
);

    // Two guard bits over the residual are enough for residual + P - M:
    // P and M never exceed 2*NUM_MID, which CNT_W already covers.
    localparam int NET_W = CNT_W + 2;

    localparam logic signed [NET_W-1:0] ONE_S     = NET_W'(1);
    localparam logic signed [NET_W-1:0] NEG_ONE_S = NET_W'(-1);
    localparam logic signed [NET_W-1:0] RES_MAX_S = NET_W'((2 ** (CNT_W - 1)) - 1);
    localparam logic signed [NET_W-1:0] RES_MIN_S = NET_W'(-(2 ** (CNT_W - 1)));
    localparam logic [LEN_W-1:0]        LAST_CNT  = LEN_W'(STREAM_LEN - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                                         state_q, state_d;
    logic [LEN_W-1:0]                               cnt_q, cnt_d;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0][CNT_W-1:0]   res_q, res_d;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0]              yp_q, yp_d, ym_q, ym_d;
    logic                                           busy_q, busy_d, done_q, done_d;

    // Datapath results for the current inputs, used only on accepted cycles.
    logic [NUM_ROWS-1:0][NUM_COLS-1:0][CNT_W-1:0]   res_nx_s;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0]              yp_s, ym_s;

    // Clamp an adjusted residual into the CNT_W signed range; never wraps.
    function automatic logic [CNT_W-1:0] sat_res(input logic signed [NET_W-1:0] v);
        logic signed [NET_W-1:0] c;
        if (v > RES_MAX_S) begin
            c = RES_MAX_S;
        end else if (v < RES_MIN_S) begin
            c = RES_MIN_S;
        end else begin
            c = v;
        end
        return c[CNT_W-1:0];
    endfunction

    // Per-output signed popcount, one-pulse emission and residual update.
    always_comb begin
        logic signed [NET_W-1:0] p_v, m_v, net_v, adj_v;
        yp_s     = '0;
        ym_s     = '0;
        res_nx_s = '0;
        p_v      = '0;
        m_v      = '0;
        net_v    = '0;
        adj_v    = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            for (int j = 0; j < NUM_COLS; j++) begin
                p_v = '0;
                m_v = '0;
                // Same-sign rail pairs are positive products; cross pairs negative.
                for (int k = 0; k < NUM_MID; k++) begin
                    p_v = p_v + NET_W'(A_p[i][k] & B_p[k][j]) + NET_W'(A_m[i][k] & B_m[k][j]);
                    m_v = m_v + NET_W'(A_p[i][k] & B_m[k][j]) + NET_W'(A_m[i][k] & B_p[k][j]);
                end
                net_v = {{(NET_W - CNT_W){res_q[i][j][CNT_W-1]}}, res_q[i][j]} + p_v - m_v;
                if (net_v >= ONE_S) begin
                    yp_s[i][j] = 1'b1;
                    adj_v      = net_v - ONE_S;
                end else if (net_v <= NEG_ONE_S) begin
                    ym_s[i][j] = 1'b1;
                    adj_v      = net_v + ONE_S;
                end else begin
                    adj_v      = '0;
                end
                res_nx_s[i][j] = sat_res(adj_v);
            end
        end
    end

    // Window FSM: start has priority, then accepted cycles advance the window.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        yp_d    = '0;
        ym_d    = '0;
        done_d  = 1'b0;
        if (start) begin
            // Inputs on a start cycle are ignored; leftover residual is dropped.
            state_d = ST_RUN;
            cnt_d   = '0;
            res_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (en) begin
                        yp_d  = yp_s;
                        ym_d  = ym_s;
                        res_d = res_nx_s;
                        cnt_d = cnt_q + LEN_W'(1);
                        // The final accepted cycle still emits its output.
                        if (cnt_q == LAST_CNT) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d == ST_RUN);
    end

    // State, window counter, residuals and registered outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            yp_q    <= '0;
            ym_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            yp_q    <= yp_d;
            ym_q    <= ym_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Y_p  = yp_q;
    assign Y_m  = ym_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_stoch_matrix_mult_signed.sv
// ---------------------------------------------------------------------------
// Directed-vector bench for stoch_matrix_mult_signed (2x2x2, CNT_W=4,
// STREAM_LEN=256). Inputs are driven 1 ns after the rising edge and outputs
// are checked at that same point, so each check sees the result of the edge
// just taken. Element [r][c] of a 2x2 packed operand is flat bit 2*r+c.
// ---------------------------------------------------------------------------
module tb_stoch_matrix_mult_signed;

    logic            CLK;
    logic            nRST;
    logic            start;
    logic            en;
    logic [1:0][1:0] a_p, a_m, b_p, b_m;
    logic [1:0][1:0] y_p, y_m;
    logic            busy, done;

    int checks;
    int failures;
    int acc;

    stoch_matrix_mult_signed dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .start (start),
        .en    (en),
        .A_p   (a_p),
        .A_m   (a_m),
        .B_p   (b_p),
        .B_m   (b_m),
        .Y_p   (y_p),
        .Y_m   (y_m),
        .busy  (busy),
        .done  (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_yp, input logic [3:0] e_ym,
                           input logic e_busy, input logic e_done);
        chk_eq({tag, "_yp"},   32'(y_p),  32'(e_yp));
        chk_eq({tag, "_ym"},   32'(y_m),  32'(e_ym));
        chk_eq({tag, "_busy"}, 32'(busy), 32'(e_busy));
        chk_eq({tag, "_done"}, 32'(done), 32'(e_done));
    endtask

    task automatic set_ops(input logic [3:0] ap, input logic [3:0] am,
                           input logic [3:0] bp, input logic [3:0] bm);
        a_p = ap;
        a_m = am;
        b_p = bp;
        b_m = bm;
    endtask

    task automatic cyc(input logic s, input logic e);
        start = s;
        en    = e;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        nRST     = 1'b0;
        start    = 1'b0;
        en       = 1'b0;
        set_ops(4'h0, 4'h0, 4'h0, 4'h0);

        // Reset state
        #13;
        chk_out("reset", 4'h0, 4'h0, 1'b0, 1'b0);
        #9 nRST = 1'b1;
        cyc(1'b0, 1'b0);
        chk_out("post_reset", 4'h0, 4'h0, 1'b0, 1'b0);

        // T1: all positive, net=2 per cycle; residual saturates at 7
        set_ops(4'hF, 4'h0, 4'hF, 4'h0);
        cyc(1'b1, 1'b1);
        chk_out("t1_start", 4'h0, 4'h0, 1'b1, 1'b0);
        for (int n = 1; n <= 20; n++) begin
            cyc(1'b0, 1'b1);
            chk_out($sformatf("t1_ones%0d", n), 4'hF, 4'h0, 1'b1, 1'b0);
        end
        // Residual held at 7 drains as exactly seven +1 pulses
        set_ops(4'h0, 4'h0, 4'h0, 4'h0);
        for (int n = 21; n <= 27; n++) begin
            cyc(1'b0, 1'b1);
            chk_out($sformatf("t1_drain%0d", n), 4'hF, 4'h0, 1'b1, 1'b0);
        end
        cyc(1'b0, 1'b1);
        chk_out("t1_drained", 4'h0, 4'h0, 1'b1, 1'b0);
        set_ops(4'hF, 4'h0, 4'hF, 4'h0);
        for (int n = 29; n <= 256; n++) begin
            cyc(1'b0, 1'b1);
            chk_out($sformatf("t1_tail%0d", n), 4'hF, 4'h0, (n < 256), (n == 256));
        end
        cyc(1'b0, 1'b1);
        chk_out("t1_idle", 4'h0, 4'h0, 1'b0, 1'b0);

        // T2: single negative product A_p[0][0] * B_m[0][0]
        set_ops(4'h1, 4'h0, 4'h0, 4'h1);
        cyc(1'b1, 1'b1);
        chk_out("t2_start", 4'h0, 4'h0, 1'b1, 1'b0);
        for (int n = 1; n <= 8; n++) begin
            cyc(1'b0, 1'b1);
            chk_out($sformatf("t2_neg%0d", n), 4'h0, 4'h1, 1'b1, 1'b0);
        end

        // T3: restart while running; P=1, M=1 on (0,0) cancels out
        set_ops(4'h3, 4'h0, 4'h1, 4'h4);
        cyc(1'b1, 1'b1);
        chk_out("t3_start", 4'h0, 4'h0, 1'b1, 1'b0);
        for (int n = 1; n <= 8; n++) begin
            cyc(1'b0, 1'b1);
            chk_out($sformatf("t3_cancel%0d", n), 4'h0, 4'h0, 1'b1, 1'b0);
        end

        // T4: en alternates 1,0 with one positive product; 512 clocks
        set_ops(4'h1, 4'h0, 4'h1, 4'h0);
        cyc(1'b1, 1'b1);
        chk_out("t4_start", 4'h0, 4'h0, 1'b1, 1'b0);
        acc = 0;
        for (int c = 0; c < 512; c++) begin
            logic e;
            e = ((c % 2) == 0);
            cyc(1'b0, e);
            if (e) acc++;
            chk_out($sformatf("t4_c%0d", c), (e ? 4'h1 : 4'h0), 4'h0,
                    (acc < 256), (e && (acc == 256)));
        end

        // T5: restart at accepted cycle 100 with residual 5
        set_ops(4'h0, 4'h0, 4'h0, 4'h0);
        cyc(1'b1, 1'b1);
        chk_out("t5_start", 4'h0, 4'h0, 1'b1, 1'b0);
        for (int n = 1; n <= 95; n++) begin
            cyc(1'b0, 1'b1);
            chk_out($sformatf("t5_zero%0d", n), 4'h0, 4'h0, 1'b1, 1'b0);
        end
        set_ops(4'hF, 4'h0, 4'hF, 4'h0);
        for (int n = 96; n <= 100; n++) begin
            cyc(1'b0, 1'b1);
            chk_out($sformatf("t5_ones%0d", n), 4'hF, 4'h0, 1'b1, 1'b0);
        end
        cyc(1'b1, 1'b1);
        chk_out("t5_restart", 4'h0, 4'h0, 1'b1, 1'b0);
        // Zero inputs: any surviving residual would still emit +1 here
        set_ops(4'h0, 4'h0, 4'h0, 4'h0);
        cyc(1'b0, 1'b1);
        chk_out("t5_res_cleared", 4'h0, 4'h0, 1'b1, 1'b0);
        for (int n = 2; n <= 256; n++) begin
            cyc(1'b0, 1'b1);
            chk_out($sformatf("t5_win%0d", n), 4'h0, 4'h0, (n < 256), (n == 256));
        end

        // T6: asynchronous reset mid-window, away from the clock edge
        set_ops(4'hF, 4'h0, 4'hF, 4'h0);
        cyc(1'b1, 1'b1);
        for (int n = 1; n <= 10; n++) begin
            cyc(1'b0, 1'b1);
            chk_out($sformatf("t6_run%0d", n), 4'hF, 4'h0, 1'b1, 1'b0);
        end
        #2 nRST = 1'b0;
        #1;
        chk_out("t6_async", 4'h0, 4'h0, 1'b0, 1'b0);
        #2 nRST = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            cyc(1'b0, 1'b1);
            chk_out($sformatf("t6_en_only%0d", n), 4'h0, 4'h0, 1'b0, 1'b0);
        end
        cyc(1'b1, 1'b1);
        chk_out("t6_restart", 4'h0, 4'h0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        chk_out("t6_resume", 4'hF, 4'h0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
